// File: rtl/fb_pkg.sv
// fb_pkg: shared types and helpers for the flattened-butterfly route-compute stage.
//   fb_dim_order_e  - which dimension is resolved first
//   fb_flit_type_e  - {head, tail} flit classification
//   fb_rc_state_e   - route-compute FSM states
//   fb_outport_idx  - dimension-ordered output port index for a destination
package fb_pkg;

  typedef enum logic {
    DimOrd0First = 1'b0,
    DimOrd1First = 1'b1
  } fb_dim_order_e;

  typedef enum logic [1:0] {
    FlitBody   = 2'b00,
    FlitTail   = 2'b01,
    FlitHead   = 2'b10,
    FlitSingle = 2'b11
  } fb_flit_type_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRouted = 2'd1,
    StDrop   = 2'd2
  } fb_rc_state_e;

  // Ports 0..R-2 reach the other dim0 routers (own coordinate skipped), ports R-1..R+C-3 the
  // other dim1 routers, and R+C-2 is the local ejection port.
  function automatic int unsigned fb_outport_idx(input int unsigned d0, input int unsigned d1,
                                                 input int unsigned cur0, input int unsigned cur1,
                                                 input int unsigned r, input int unsigned c,
                                                 input fb_dim_order_e order);
    int unsigned p0;
    int unsigned p1;
    int unsigned idx;
    p0  = (d0 < cur0) ? d0 : d0 - 1;
    p1  = (r - 1) + ((d1 < cur1) ? d1 : d1 - 1);
    idx = r + c - 2;
    if (order == DimOrd0First) begin
      if (d0 != cur0)      idx = p0;
      else if (d1 != cur1) idx = p1;
    end else begin
      if (d1 != cur1)      idx = p1;
      else if (d0 != cur0) idx = p0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fb_flit_fifo.sv
// fb_flit_fifo: DEPTH-entry flit buffer holding {head, tail, dest, data}.
//   i_push/i_pop      - write/read requests; ignored when full/empty respectively
//   i_head..i_data    - flit written on push
//   o_head..o_data    - flit at the FIFO head (undefined while empty)
//   o_full/o_empty    - occupancy flags
// Push and pop in the same cycle are both honoured; there is no bypass path.
module fb_flit_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_head,
  input  logic              i_tail,
  input  logic [DEST_W-1:0] i_dest,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_head,
  output logic              o_tail,
  output logic [DEST_W-1:0] o_dest,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = 2 + DEST_W + DATA_W;

  logic [EW-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]   r_wr_ptr;
  logic [PW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_rd_entry;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= {i_head, i_tail, i_dest, i_data};
  end

  assign w_rd_entry                       = r_mem[r_rd_ptr[PW-1:0]];
  assign {o_head, o_tail, o_dest, o_data} = w_rd_entry;

endmodule

// File: rtl/fb_route_stage.sv
// fb_route_stage: per-input-port route-compute stage of a flattened-butterfly router.
//   clk, rst_n                    - clock, async active-low reset
//   in_valid/in_ready             - flit input handshake
//   in_head/in_tail/in_dest/in_data - input flit fields; dest = {d1, d0}, used on head only
//   request_vec                   - one-hot output port request to the switch allocator
//   out_valid/out_ready           - flit output handshake (out_ready = allocator grant)
//   out_head/out_tail/out_data    - FIFO-head flit fields
//   err_o                         - one-cycle pulse per bad destination or headless flit
// The route is computed once per packet from the head flit and held until the tail leaves.
module fb_route_stage
  import fb_pkg::*;
#(
  parameter int unsigned NODE_PER_ROW = 4,
  parameter int unsigned NODE_PER_COL = 4,
  parameter int unsigned CURR_DIM0    = 1,
  parameter int unsigned CURR_DIM1    = 1,
  parameter int unsigned DIM_ORDER    = 0,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 2
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic                                                   in_head,
  input  logic                                                   in_tail,
  input  logic [$clog2(NODE_PER_ROW)+$clog2(NODE_PER_COL)-1:0]   in_dest,
  input  logic [DATA_W-1:0]                                      in_data,
  output logic [NODE_PER_ROW+NODE_PER_COL-2:0]                   request_vec,
  input  logic                                                   out_ready,
  output logic                                                   out_valid,
  output logic                                                   out_head,
  output logic                                                   out_tail,
  output logic [DATA_W-1:0]                                      out_data,
  output logic                                                   err_o
);

  localparam int unsigned D0W      = $clog2(NODE_PER_ROW);
  localparam int unsigned D1W      = $clog2(NODE_PER_COL);
  localparam int unsigned DESTID_W = D0W + D1W;
  localparam int unsigned OUTPORT  = NODE_PER_ROW + NODE_PER_COL - 1;
  localparam int unsigned OPW      = $clog2(OUTPORT);
  localparam fb_dim_order_e Order  = (DIM_ORDER != 0) ? DimOrd1First : DimOrd0First;

  fb_rc_state_e        r_state;
  logic [OPW-1:0]      r_route;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_fifo_head;
  logic                w_fifo_tail;
  logic [DESTID_W-1:0] w_fifo_dest;
  logic [DATA_W-1:0]   w_fifo_data;
  logic [D0W-1:0]      w_d0;
  logic [D1W-1:0]      w_d1;
  logic                w_dest_ok;
  logic [OPW-1:0]      w_route_idx;
  fb_flit_type_e       w_ftype;
  logic                w_out_valid;
  logic                w_err;

  // Held at 0 through reset so no flit is accepted while the FIFO is being cleared.
  assign in_ready = rst_n & ~w_full;
  assign w_push   = in_valid & in_ready;

  fb_flit_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .DEST_W (DESTID_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_head  (in_head),
    .i_tail  (in_tail),
    .i_dest  (in_dest),
    .i_data  (in_data),
    .o_head  (w_fifo_head),
    .o_tail  (w_fifo_tail),
    .o_dest  (w_fifo_dest),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_d0        = w_fifo_dest[D0W-1:0];
  assign w_d1        = w_fifo_dest[DESTID_W-1:D0W];
  // Non-power-of-two dimensions leave encodable coordinates with no router behind them.
  assign w_dest_ok   = (32'(w_d0) < NODE_PER_ROW) && (32'(w_d1) < NODE_PER_COL);
  assign w_route_idx = OPW'(fb_outport_idx(32'(w_d0), 32'(w_d1), CURR_DIM0, CURR_DIM1,
                                           NODE_PER_ROW, NODE_PER_COL, Order));
  assign w_ftype     = fb_flit_type_e'({w_fifo_head, w_fifo_tail});
  assign w_out_valid = (r_state == StRouted) & ~w_empty;

  always_comb begin
    w_pop = 1'b0;
    w_err = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          case (w_ftype)
            FlitHead, FlitSingle: begin
              // A good head stays in the FIFO; it leaves once the route is locked.
              if (!w_dest_ok) begin
                w_err = 1'b1;
                w_pop = w_fifo_tail;
              end
            end
            default: begin
              w_err = 1'b1;
              w_pop = 1'b1;
            end
          endcase
        end
      end
      StRouted: w_pop = w_out_valid & out_ready;
      StDrop:   w_pop = ~w_empty;
      default:  w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_route <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!w_empty && w_fifo_head) begin
            if (w_dest_ok) begin
              r_route <= w_route_idx;
              r_state <= StRouted;
            end else if (!w_fifo_tail) begin
              r_state <= StDrop;
            end
          end
        end
        StRouted: if (w_pop && w_fifo_tail) r_state <= StIdle;
        StDrop:   if (w_pop && w_fifo_tail) r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
    end
  end

  assign out_valid   = w_out_valid;
  assign out_head    = w_fifo_head;
  assign out_tail    = w_fifo_tail;
  assign out_data    = w_fifo_data;
  assign request_vec = w_out_valid ? ({{(OUTPORT-1){1'b0}}, 1'b1} << r_route) : '0;
  assign err_o       = w_err;

endmodule
